// File: rtl/loxodes_pkg.sv
// rtl/loxodes_pkg.sv - shared state encoding, default sizes and one-hot index helper
package loxodes_pkg;

  localparam int NCH_DEF  = 7;
  localparam int DW_DEF   = 5;
  localparam int ERRW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  // Highest set bit wins; callers only trust the result when the code is one-hot.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] code);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (code[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/loxodes_onehot_decode.sv
// rtl/loxodes_onehot_decode.sv - one-hot validity flag and binary index of a channel code
module loxodes_onehot_decode
  import loxodes_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0] code,
  output logic           onehot,
  output logic [2:0]     idx
);

  logic [7:0] code_ext;

  always_comb begin
    code_ext = '0;
    code_ext[NCH-1:0] = code;
  end

  assign onehot = ($countones(code) == 1);
  assign idx    = onehot_to_idx(code_ext);

endmodule

// File: rtl/loxodes_sequence_monitor.sv
// rtl/loxodes_sequence_monitor.sv - checks a rotating one-hot sequencer for order and dwell time
module loxodes_sequence_monitor
  import loxodes_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int DW   = DW_DEF,
  parameter int ERRW = ERRW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [DW-1:0]   delay,
  input  logic [NCH-1:0]  channel,
  output logic            locked,
  output logic            step_valid,
  output logic [2:0]      chan_idx,
  output logic [DW:0]     last_dwell,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  localparam logic [2:0]  LAST_IDX  = 3'(NCH - 1);
  localparam logic [3:0]  GOOD_LOCK = 4'(NCH);
  localparam logic [DW:0] DWELL_ONE = (DW + 1)'(1);
  localparam logic [DW:0] DWELL_MAX = '1;

  state_t         state;
  logic [NCH-1:0] ch_q;
  logic [NCH-1:0] ch_prev;
  logic [DW:0]    dwell;
  logic [3:0]     good_cnt;
  logic [2:0]     ref_idx;
  logic           ref_valid;

  logic        onehot;
  logic [2:0]  cur_idx;
  logic        step;
  logic        illegal;
  logic [2:0]  expect_idx;
  logic [DW:0] dwell_target;
  logic        good_step;
  logic        dwell_full;

  loxodes_onehot_decode #(.NCH(NCH)) u_decode (
    .code   (ch_q),
    .onehot (onehot),
    .idx    (cur_idx)
  );

  assign step         = onehot && (ch_q != ch_prev);
  assign illegal      = !onehot;
  assign expect_idx   = (ref_idx == LAST_IDX) ? 3'd0 : ref_idx + 3'd1;
  assign dwell_target = {1'b0, delay} + DWELL_ONE;
  assign good_step    = ref_valid && (cur_idx == expect_idx) && (dwell == dwell_target);
  assign dwell_full   = (dwell == DWELL_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ch_q       <= '0;
      ch_prev    <= '0;
      dwell      <= '0;
      good_cnt   <= '0;
      ref_idx    <= '0;
      ref_valid  <= 1'b0;
      locked     <= 1'b0;
      step_valid <= 1'b0;
      chan_idx   <= '0;
      last_dwell <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      ch_q       <= channel;
      ch_prev    <= ch_q;
      step_valid <= 1'b0;
      err        <= 1'b0;
      if (!enable || state == ST_IDLE) begin
        state     <= enable ? ST_ACQUIRE : ST_IDLE;
        dwell     <= '0;
        good_cnt  <= '0;
        ref_idx   <= '0;
        ref_valid <= 1'b0;
        locked    <= 1'b0;
      end else begin
        // Every step re-anchors the reference, so a bad step becomes the new starting point.
        if (step) begin
          step_valid <= 1'b1;
          chan_idx   <= cur_idx;
          last_dwell <= dwell;
          ref_idx    <= cur_idx;
          ref_valid  <= 1'b1;
          dwell      <= DWELL_ONE;
        end else if (!dwell_full) begin
          dwell <= dwell + DWELL_ONE;
        end

        case (state)
          ST_ACQUIRE: begin
            if (step && good_step) begin
              if (good_cnt + 4'd1 == GOOD_LOCK) begin
                state    <= ST_TRACK;
                locked   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end else if (step || illegal) begin
              good_cnt <= '0;
            end
          end
          ST_TRACK: begin
            if ((step && !good_step) || illegal || dwell_full) begin
              state  <= ST_FAULT;
              locked <= 1'b0;
              err    <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERRW'(1);
            end
          end
          ST_FAULT: begin
            state    <= ST_ACQUIRE;
            good_cnt <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loxodes_sequence_monitor.sv
// tb/tb_loxodes_sequence_monitor.sv - directed and randomized checks against a behavioural model
module tb_loxodes_sequence_monitor;

  localparam int NCH  = 7;
  localparam int DW   = 5;
  localparam int ERRW = 8;
  localparam int DMAX = (1 << (DW + 1)) - 1;
  localparam int EMAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [DW-1:0]   delay;
  logic [NCH-1:0]  channel;
  logic            locked;
  logic            step_valid;
  logic [2:0]      chan_idx;
  logic [DW:0]     last_dwell;
  logic            err;
  logic [ERRW-1:0] err_count;

  loxodes_sequence_monitor #(.NCH(NCH), .DW(DW), .ERRW(ERRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .delay      (delay),
    .channel    (channel),
    .locked     (locked),
    .step_valid (step_valid),
    .chan_idx   (chan_idx),
    .last_dwell (last_dwell),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 acquire, 2 track, 3 fault
  int           m_mode, m_dwell, m_good, m_ref;
  bit           m_refv;
  bit [NCH-1:0] m_chq, m_chprev;
  int           m_locked, m_sv, m_idx, m_last, m_err, m_errcnt;

  int steps_seen, errs_seen, lock_at, last_ld, prev_locked;
  int pos;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_dwell = 0; m_good = 0; m_ref = 0; m_refv = 0;
    m_chq = '0; m_chprev = '0;
    m_locked = 0; m_sv = 0; m_idx = 0; m_last = 0; m_err = 0; m_errcnt = 0;
  endtask

  task automatic model_edge();
    int ones, idx;
    bit stp, ok;
    if (!rst) begin
      model_clear();
      return;
    end
    ones = $countones(m_chq);
    idx = 0;
    for (int i = 0; i < NCH; i++) if (m_chq[i]) idx = i;
    stp = (ones == 1) && (m_chq != m_chprev);
    ok  = m_refv && (idx == (m_ref + 1) % NCH) && (m_dwell == int'(delay) + 1);
    m_sv = 0;
    m_err = 0;
    if (!enable || m_mode == 0) begin
      m_mode = enable ? 1 : 0;
      m_dwell = 0; m_good = 0; m_ref = 0; m_refv = 0; m_locked = 0;
    end else begin
      if (m_mode == 1) begin
        if (stp && ok) begin
          m_good++;
          if (m_good == NCH) begin m_mode = 2; m_locked = 1; m_good = 0; end
        end else if (stp || ones != 1) m_good = 0;
      end else if (m_mode == 2) begin
        if ((stp && !ok) || ones != 1 || m_dwell == DMAX) begin
          m_mode = 3; m_locked = 0; m_err = 1;
          if (m_errcnt < EMAX) m_errcnt++;
        end
      end else begin
        m_mode = 1; m_good = 0;
      end
      if (stp) begin
        m_sv = 1; m_idx = idx; m_last = m_dwell; m_ref = idx; m_refv = 1; m_dwell = 1;
      end else if (m_dwell < DMAX) m_dwell++;
    end
    m_chprev = m_chq;
    m_chq = channel;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("locked", locked, m_locked);
    chk("step_valid", step_valid, m_sv);
    chk("chan_idx", chan_idx, m_idx);
    chk("last_dwell", last_dwell, m_last);
    chk("err", err, m_err);
    chk("err_count", err_count, m_errcnt);
    if (step_valid) begin steps_seen++; last_ld = last_dwell; end
    if (err) errs_seen++;
    if (locked && !prev_locked) lock_at = steps_seen;
    prev_locked = locked;
  endtask

  task automatic rotate(input int n, input int hold);
    for (int s = 0; s < n; s++) begin
      pos = (pos + 1) % NCH;
      channel = 7'(1) << pos;
      repeat (hold) tick();
    end
  endtask

  initial begin
    int base_s, base_e, hold, glitch;
    steps_seen = 0; errs_seen = 0; lock_at = -1; last_ld = -1; prev_locked = 0;
    rst = 1'b0; enable = 1'b0; delay = '0; channel = '0; pos = NCH - 1;
    model_clear();
    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_last_dwell", last_dwell, 0);
    rst = 1'b1;
    tick();

    // Clean rotation: lock on 8th step, dwell 4
    enable = 1'b1; delay = 5'd3;
    base_s = steps_seen;
    rotate(8, 4);
    chk("clean_steps", steps_seen - base_s, 8);
    chk("clean_lock_step", lock_at - base_s, 8);
    chk("clean_locked", locked, 1);
    chk("clean_last_dwell", last_ld, 4);

    // Order broken 2 -> 4
    rotate(2, 4);
    base_e = errs_seen;
    pos = 4; channel = 7'(1) << pos;
    repeat (4) tick();
    chk("order_err_pulses", errs_seen - base_e, 1);
    chk("order_err_count", err_count, 1);
    chk("order_locked", locked, 0);
    rotate(6, 4);
    chk("relock_after_6", locked, 0);
    rotate(1, 4);
    chk("relock_after_7", locked, 1);

    // One-cycle all-zero code while locked
    base_e = errs_seen;
    channel = '0;
    tick();
    channel = 7'(1) << pos;
    repeat (4) tick();
    chk("zero_err_pulses", errs_seen - base_e, 1);
    chk("zero_err_count", err_count, 2);
    chk("zero_chan_idx", chan_idx, pos);
    rotate(7, 4);
    chk("zero_relock", locked, 1);

    // Delay change while locked
    delay = 5'd5;
    rotate(1, 4);
    chk("delay_err_count", err_count, 3);
    chk("delay_locked", locked, 0);
    chk("delay_last_dwell", last_ld, 4);

    // Dwell timeout with delay 31
    delay = 5'd31;
    rotate(8, 32);
    chk("slow_locked", locked, 1);
    repeat (70) tick();
    chk("timeout_err_count", err_count, 4);
    chk("timeout_locked", locked, 0);

    // Saturation of the fault counter
    delay = 5'd0;
    base_e = errs_seen;
    for (int k = 0; k < 300; k++) begin
      rotate(10, 1);
      pos = (pos + 2) % NCH;
      channel = 7'(1) << pos;
      tick();
    end
    repeat (3) tick();
    chk("sat_err_pulses", errs_seen - base_e, 300);
    chk("sat_err_count", err_count, 255);

    // Asynchronous reset mid-TRACK
    delay = 5'd3;
    rotate(9, 4);
    chk("pre_rst_locked", locked, 1);
    #3 rst = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err", err, 0);
    chk("async_err_count", err_count, 0);
    chk("async_step_valid", step_valid, 0);
    repeat (2) tick();
    rst = 1'b1;

    // Randomized rotation with glitches, skips, delay changes and enable drops
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(0, 39) == 0) delay = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        enable = 1'b1;
      end
      glitch = $urandom_range(0, 24);
      if (glitch == 0) begin
        channel = 7'($urandom_range(0, 127));
        tick();
      end
      pos = (pos + (($urandom_range(0, 29) == 0) ? 2 : 1)) % NCH;
      channel = 7'(1) << pos;
      hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : int'(delay) + 1;
      repeat (hold) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
